// File: rtl/ti_kbd_pkg.sv
// Shared definitions for the PS/2 to TI-99/4A keyboard matrix engine:
// prefix codes, state enums, joystick rows and the scancode lookup.
package ti_kbd_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_PAUSE = 8'hE1;
    localparam logic [7:0] SC_CAPS  = 8'h58;
    localparam logic [7:0] SC_FN    = 8'h11;

    localparam int FN_ROW = 4;
    localparam int FN_COL = 7;

    localparam int JOY_FIRE_ROW  = 0;
    localparam int JOY_LEFT_ROW  = 1;
    localparam int JOY_RIGHT_ROW = 2;
    localparam int JOY_DOWN_ROW  = 3;
    localparam int JOY_UP_ROW    = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXT     = 3'd1,
        BRK     = 3'd2,
        EXT_BRK = 3'd3,
        SKIP    = 3'd4
    } pfx_state_t;

    typedef enum logic [1:0] {
        C_IDLE  = 2'd0,
        C_LEAD  = 2'd1,
        C_HOLD  = 2'd2,
        C_TRAIL = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic       valid;
        logic       composite;
        logic [3:0] row;
        logic [3:0] col;
    } key_map_t;

    // Arrow keys are composites: FN plus the E/S/D/X key they sit on.
    function automatic key_map_t map_scancode(input logic ext, input logic [7:0] code);
        key_map_t m;
        case ({ext, code})
            9'h01C:  m = '{1'b1, 1'b0, 4'd5, 4'd2};   // A
            9'h01B:  m = '{1'b1, 1'b0, 4'd5, 4'd1};   // S
            9'h023:  m = '{1'b1, 1'b0, 4'd5, 4'd3};   // D
            9'h024:  m = '{1'b1, 1'b0, 4'd6, 4'd2};   // E
            9'h022:  m = '{1'b1, 1'b0, 4'd7, 4'd1};   // X
            9'h029:  m = '{1'b1, 1'b0, 4'd1, 4'd0};   // space
            9'h05A:  m = '{1'b1, 1'b0, 4'd2, 4'd0};   // enter
            9'h012:  m = '{1'b1, 1'b0, 4'd3, 4'd0};   // left shift
            9'h014:  m = '{1'b1, 1'b0, 4'd6, 4'd0};   // ctrl
            9'h011:  m = '{1'b1, 1'b0, 4'd4, 4'd7};   // left alt = FN
            9'h175:  m = '{1'b1, 1'b1, 4'd6, 4'd2};   // up    -> FN+E
            9'h16B:  m = '{1'b1, 1'b1, 4'd5, 4'd1};   // left  -> FN+S
            9'h174:  m = '{1'b1, 1'b1, 4'd5, 4'd3};   // right -> FN+D
            9'h172:  m = '{1'b1, 1'b1, 4'd7, 4'd1};   // down  -> FN+X
            default: m = '{1'b0, 1'b0, 4'd0, 4'd0};
        endcase
        return m;
    endfunction

    function automatic logic joy_bit(input logic [4:0] jv, input int r);
        case (r)
            JOY_FIRE_ROW:  return jv[0];
            JOY_LEFT_ROW:  return jv[1];
            JOY_RIGHT_ROW: return jv[2];
            JOY_DOWN_ROW:  return jv[3];
            JOY_UP_ROW:    return jv[4];
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ti_key_seq.sv
// Composite-key sequencer: raises FN, waits MOD_LEAD cycles, asserts the
// target key; on release drops the key first and FN MOD_LEAD cycles later.
module ti_key_seq
    import ti_kbd_pkg::*;
#(
    parameter int MOD_LEAD = 4096
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       ev_valid,
    input  logic       ev_brk,
    input  logic [7:0] ev_code,
    input  logic [3:0] tgt_row,
    input  logic [3:0] tgt_col,
    output logic       fn_syn,
    output logic       key_on,
    output logic [3:0] key_row,
    output logic [3:0] key_col
);

    localparam logic [15:0] LEAD_M1 = 16'(MOD_LEAD - 1);

    seq_state_t  state_r;
    logic [15:0] cnt_r;
    logic [7:0]  act_code_r;
    logic        fn_syn_r;
    logic        key_on_r;
    logic [3:0]  key_row_r;
    logic [3:0]  key_col_r;
    logic        act_brk_s;

    assign act_brk_s = ev_valid && ev_brk && (ev_code == act_code_r);

    // Sequencer state, lead/trail counter and registered FN/key outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= C_IDLE;
            cnt_r      <= 16'd0;
            act_code_r <= 8'd0;
            fn_syn_r   <= 1'b0;
            key_on_r   <= 1'b0;
            key_row_r  <= 4'd0;
            key_col_r  <= 4'd0;
        end else if (clr) begin
            state_r  <= C_IDLE;
            cnt_r    <= 16'd0;
            fn_syn_r <= 1'b0;
            key_on_r <= 1'b0;
        end else begin
            case (state_r)
                C_IDLE: begin
                    if (ev_valid && !ev_brk) begin
                        fn_syn_r   <= 1'b1;
                        cnt_r      <= LEAD_M1;
                        act_code_r <= ev_code;
                        key_row_r  <= tgt_row;
                        key_col_r  <= tgt_col;
                        state_r    <= C_LEAD;
                    end
                end
                C_LEAD: begin
                    if (act_brk_s) begin
                        cnt_r   <= LEAD_M1;
                        state_r <= C_TRAIL;
                    end else if (cnt_r == 16'd0) begin
                        key_on_r <= 1'b1;
                        state_r  <= C_HOLD;
                    end else begin
                        cnt_r <= cnt_r - 16'd1;
                    end
                end
                C_HOLD: begin
                    if (act_brk_s) begin
                        key_on_r <= 1'b0;
                        cnt_r    <= LEAD_M1;
                        state_r  <= C_TRAIL;
                    end
                end
                C_TRAIL: begin
                    if (cnt_r == 16'd0) begin
                        fn_syn_r <= 1'b0;
                        state_r  <= C_IDLE;
                    end else begin
                        cnt_r <= cnt_r - 16'd1;
                    end
                end
                default: begin
                    state_r  <= C_IDLE;
                    fn_syn_r <= 1'b0;
                    key_on_r <= 1'b0;
                end
            endcase
        end
    end

    assign fn_syn  = fn_syn_r;
    assign key_on  = key_on_r;
    assign key_row = key_row_r;
    assign key_col = key_col_r;

endmodule

// File: rtl/ti_keymatrix_gen.sv
// PS/2 set-2 byte stream to TI-99/4A keyboard matrix: prefix parsing,
// key matrix, Alpha Lock, joystick merge and active-low row return.
module ti_keymatrix_gen
    import ti_kbd_pkg::*;
#(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int NJOY     = 2,
    parameter int MOD_LEAD = 4096,
    parameter int AL_ROW   = 4
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              byte_valid,
    input  logic [7:0]        ps2_byte,
    input  logic              kbd_clear,
    input  logic              joy_swap,
    input  logic [NJOY*5-1:0] joy,
    input  logic [COLS-1:0]   sel_n,
    input  logic              al_sel_n,
    output logic [ROWS-1:0]   rows_n,
    output logic              alpha_lock
);

    pfx_state_t                 pfx_state_r;
    logic [2:0]                 skip_cnt_r;
    logic [ROWS-1:0][COLS-1:0]  mat_r;
    logic [ROWS-1:0][COLS-1:0]  eff_s;
    logic                       caps_held_r;
    logic                       alpha_lock_r;
    logic [ROWS-1:0]            rows_n_s;

    logic        is_prefix_s;
    logic        ev_valid_s;
    logic        ev_ext_s;
    logic        ev_brk_s;
    logic        caps_ev_s;
    logic        plain_ev_s;
    logic        comp_ev_s;
    key_map_t    km_s;
    logic        fn_syn_s;
    logic        key_on_s;
    logic [3:0]  key_row_s;
    logic [3:0]  key_col_s;
    logic [NJOY*5-1:0] joy_sw_s;
    logic [4:0]  joy_col_s [COLS];

    assign is_prefix_s = (ps2_byte == SC_EXT) || (ps2_byte == SC_BRK) || (ps2_byte == SC_PAUSE);
    assign ev_valid_s  = byte_valid && !kbd_clear && (pfx_state_r != SKIP) && !is_prefix_s;
    assign ev_ext_s    = (pfx_state_r == EXT) || (pfx_state_r == EXT_BRK);
    assign ev_brk_s    = (pfx_state_r == BRK) || (pfx_state_r == EXT_BRK);
    assign km_s        = map_scancode(ev_ext_s, ps2_byte);
    assign caps_ev_s   = ev_valid_s && !ev_ext_s && (ps2_byte == SC_CAPS);
    assign plain_ev_s  = ev_valid_s && km_s.valid && !km_s.composite;
    assign comp_ev_s   = ev_valid_s && km_s.valid && km_s.composite;

    // Prefix parser; E1 swallows the remaining seven bytes of Pause.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pfx_state_r <= IDLE;
            skip_cnt_r  <= 3'd0;
        end else if (kbd_clear) begin
            pfx_state_r <= IDLE;
            skip_cnt_r  <= 3'd0;
        end else if (byte_valid) begin
            case (pfx_state_r)
                SKIP: begin
                    if (skip_cnt_r == 3'd1) begin
                        pfx_state_r <= IDLE;
                    end
                    skip_cnt_r <= skip_cnt_r - 3'd1;
                end
                IDLE, EXT, BRK, EXT_BRK: begin
                    if (ps2_byte == SC_PAUSE) begin
                        pfx_state_r <= SKIP;
                        skip_cnt_r  <= 3'd7;
                    end else if (ps2_byte == SC_EXT) begin
                        pfx_state_r <= ev_brk_s ? EXT_BRK : EXT;
                    end else if (ps2_byte == SC_BRK) begin
                        pfx_state_r <= ev_ext_s ? EXT_BRK : BRK;
                    end else begin
                        pfx_state_r <= IDLE;
                    end
                end
                default: begin
                    pfx_state_r <= IDLE;
                    skip_cnt_r  <= 3'd0;
                end
            endcase
        end
    end

    // Plain key matrix: make sets, break clears the mapped position.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mat_r <= {(ROWS*COLS){1'b0}};
        end else if (kbd_clear) begin
            mat_r <= {(ROWS*COLS){1'b0}};
        end else if (plain_ev_s) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (r == int'(km_s.row) && c == int'(km_s.col)) begin
                        mat_r[r][c] <= !ev_brk_s;
                    end
                end
            end
        end
    end

    // Alpha Lock toggles on the first make only; typematic repeats are held off.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            caps_held_r  <= 1'b0;
            alpha_lock_r <= 1'b0;
        end else if (kbd_clear) begin
            caps_held_r <= 1'b0;
        end else if (caps_ev_s) begin
            if (ev_brk_s) begin
                caps_held_r <= 1'b0;
            end else begin
                caps_held_r <= 1'b1;
                if (!caps_held_r) begin
                    alpha_lock_r <= !alpha_lock_r;
                end
            end
        end
    end

    ti_key_seq #(
        .MOD_LEAD (MOD_LEAD)
    ) u_seq (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .clr      (kbd_clear),
        .ev_valid (comp_ev_s),
        .ev_brk   (ev_brk_s),
        .ev_code  (ps2_byte),
        .tgt_row  (km_s.row),
        .tgt_col  (km_s.col),
        .fn_syn   (fn_syn_s),
        .key_on   (key_on_s),
        .key_row  (key_row_s),
        .key_col  (key_col_s)
    );

    if (NJOY >= 2) begin : g_swap
        // Channel 0/1 exchange; higher channels pass straight through.
        always_comb begin
            joy_sw_s = joy;
            if (joy_swap) begin
                joy_sw_s[4:0] = joy[9:5];
                joy_sw_s[9:5] = joy[4:0];
            end else begin
                joy_sw_s = joy;
            end
        end
    end else begin : g_noswap
        assign joy_sw_s = joy;
    end

    for (genvar c = 0; c < COLS; c++) begin : g_joy
        if (c < NJOY) begin : g_on
            assign joy_col_s[c] = joy_sw_s[(NJOY-1-c)*5 +: 5];
        end else begin : g_off
            assign joy_col_s[c] = 5'd0;
        end
    end

    // Effective matrix and active-low row reduction under the column selects.
    always_comb begin
        eff_s    = mat_r;
        rows_n_s = {ROWS{1'b1}};
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                eff_s[r][c] = mat_r[r][c]
                            | joy_bit(joy_col_s[c], r)
                            | (fn_syn_s && r == FN_ROW && c == FN_COL)
                            | (key_on_s && r == int'(key_row_s) && c == int'(key_col_s));
            end
            rows_n_s[r] = !((|(eff_s[r] & ~sel_n))
                          || (r == AL_ROW && alpha_lock_r && !al_sel_n));
        end
    end

    assign rows_n     = rows_n_s;
    assign alpha_lock = alpha_lock_r;

endmodule

// File: tb/tb_ti_keymatrix_gen.sv
// Directed bench for ti_keymatrix_gen with MOD_LEAD=4.
module tb_ti_keymatrix_gen;

    logic       clk_sys;
    logic       reset_n;
    logic       byte_valid;
    logic [7:0] ps2_byte;
    logic       kbd_clear;
    logic       joy_swap;
    logic [9:0] joy;
    logic [7:0] sel_n;
    logic       al_sel_n;
    logic [7:0] rows_n;
    logic       alpha_lock;

    int checks;
    int errors;

    ti_keymatrix_gen #(
        .ROWS     (8),
        .COLS     (8),
        .NJOY     (2),
        .MOD_LEAD (4),
        .AL_ROW   (4)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .byte_valid (byte_valid),
        .ps2_byte   (ps2_byte),
        .kbd_clear  (kbd_clear),
        .joy_swap   (joy_swap),
        .joy        (joy),
        .sel_n      (sel_n),
        .al_sel_n   (al_sel_n),
        .rows_n     (rows_n),
        .alpha_lock (alpha_lock)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        ps2_byte   = b;
        tick(1);
        byte_valid = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset_n    = 1'b0;
        byte_valid = 1'b0;
        ps2_byte   = 8'h00;
        kbd_clear  = 1'b0;
        joy_swap   = 1'b0;
        joy        = 10'd0;
        sel_n      = 8'h00;
        al_sel_n   = 1'b0;

        // Reset state
        #1;
        check_val("reset_rows", rows_n, 8'hFF);
        check_val("reset_al", {7'd0, alpha_lock}, 8'h00);
        al_sel_n = 1'b1;
        tick(2);
        reset_n = 1'b1;
        tick(1);
        check_val("idle_rows", rows_n, 8'hFF);

        // Plain key A at [5][2]
        sel_n = 8'hFB;
        send_byte(8'h1C);
        check_val("a_make", rows_n, 8'hDF);
        send_byte(8'hF0);
        check_val("a_brk_prefix", rows_n, 8'hDF);
        send_byte(8'h1C);
        check_val("a_break", rows_n, 8'hFF);

        // Physical FN (left Alt) at [4][7]
        sel_n = 8'h7F;
        send_byte(8'h11);
        check_val("fn_phys_make", rows_n, 8'hEF);
        send_byte(8'hF0);
        send_byte(8'h11);
        check_val("fn_phys_break", rows_n, 8'hFF);

        // Composite up: FN at +1, E [6][2] four cycles later
        sel_n = 8'h7B;
        send_byte(8'hE0);
        send_byte(8'h75);
        check_val("up_fn_first", rows_n, 8'hEF);
        send_byte(8'hE0);
        send_byte(8'h75);
        tick(1);
        check_val("up_lead_repeat", rows_n, 8'hEF);
        tick(1);
        check_val("up_key_on", rows_n, 8'hAF);
        tick(2);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        check_val("up_key_off", rows_n, 8'hEF);
        tick(3);
        check_val("up_fn_trail", rows_n, 8'hEF);
        tick(1);
        check_val("up_fn_off", rows_n, 8'hFF);

        // Alpha Lock with typematic repeat
        sel_n = 8'hFF;
        send_byte(8'h58);
        check_val("caps_toggle", {7'd0, alpha_lock}, 8'h01);
        check_val("caps_unsel", rows_n, 8'hFF);
        send_byte(8'h58);
        send_byte(8'h58);
        send_byte(8'hF0);
        send_byte(8'h58);
        check_val("caps_repeat", {7'd0, alpha_lock}, 8'h01);
        al_sel_n = 1'b0;
        #1;
        check_val("caps_sel", rows_n, 8'hEF);
        al_sel_n = 1'b1;
        send_byte(8'h58);
        send_byte(8'hF0);
        send_byte(8'h58);
        check_val("caps_toggle_off", {7'd0, alpha_lock}, 8'h00);

        // Joystick merge and swap
        joy   = 10'b00000_00001;
        sel_n = 8'hFD;
        #1;
        check_val("joy0_fire", rows_n, 8'hFE);
        joy_swap = 1'b1;
        #1;
        check_val("joy0_swap_col1", rows_n, 8'hFF);
        sel_n = 8'hFE;
        #1;
        check_val("joy0_swap_col0", rows_n, 8'hFE);
        joy_swap = 1'b0;
        joy      = 10'b10000_00000;
        #1;
        check_val("joy1_up", rows_n, 8'hEF);
        joy = 10'd0;

        // Pause sequence is skipped for exactly seven bytes
        sel_n = 8'h00;
        send_byte(8'hE1);
        send_byte(8'h1C);
        send_byte(8'h77);
        send_byte(8'hE1);
        send_byte(8'hF0);
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h77);
        check_val("pause_skip", rows_n, 8'hFF);
        send_byte(8'h1C);
        check_val("after_pause", rows_n, 8'hDF);
        send_byte(8'hF0);
        send_byte(8'h1C);

        // Reset in the middle of a composite lead
        sel_n = 8'h7B;
        send_byte(8'hE0);
        send_byte(8'h6B);
        check_val("left_fn", rows_n, 8'hEF);
        tick(2);
        reset_n = 1'b0;
        #1;
        check_val("midlead_reset", rows_n, 8'hFF);
        tick(1);
        reset_n = 1'b1;
        tick(1);
        send_byte(8'hE0);
        send_byte(8'h75);
        check_val("post_reset_fn", rows_n, 8'hEF);
        tick(4);
        check_val("post_reset_key", rows_n, 8'hAF);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        tick(5);
        check_val("post_reset_idle", rows_n, 8'hFF);

        // Clear during hold keeps Alpha Lock
        sel_n = 8'h77;
        send_byte(8'h58);
        send_byte(8'hF0);
        send_byte(8'h58);
        send_byte(8'hE0);
        send_byte(8'h74);
        tick(6);
        check_val("right_hold", rows_n, 8'hCF);
        kbd_clear = 1'b1;
        tick(1);
        kbd_clear = 1'b0;
        check_val("clear_rows", rows_n, 8'hFF);
        check_val("clear_keeps_al", {7'd0, alpha_lock}, 8'h01);

        // Byte coinciding with clear is discarded
        sel_n      = 8'hFB;
        kbd_clear  = 1'b1;
        byte_valid = 1'b1;
        ps2_byte   = 8'h1C;
        tick(1);
        kbd_clear  = 1'b0;
        byte_valid = 1'b0;
        check_val("clear_wins", rows_n, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
